// File: rtl/saturn_serial_tx.sv
// Debug character transmitter: buffers bytes from the bus controller in a FIFO
// and sends each one as an 8N1 asynchronous frame on o_tx.
module saturn_serial_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [7:0]         i_char_to_send,
  input  logic               i_char_valid,
  input  logic               i_char_send,
  output logic               o_serial_busy,
  output logic               o_tx,
  output logic [FIFO_AW:0]   o_fifo_count
);

  localparam int                  DEPTH       = 1 << FIFO_AW;
  localparam int                  BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]   BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]   BAUD_ZERO   = {BAUD_W{1'b0}};
  localparam logic [FIFO_AW:0]    FULL_CNT    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]    EMPTY_CNT   = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0]    ONE_CNT     = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0]  ONE_PTR     = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic [FIFO_AW:0]    w_count_next;
  logic                r_busy;
  logic                r_tx;
  logic                w_tx_next;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_next;
  logic [BAUD_W-1:0]   r_baud;
  logic [BAUD_W-1:0]   w_baud_next;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_next;
  logic                w_push;
  logic                w_pop;
  logic                w_baud_zero;
  logic                w_fifo_has_data;

  assign w_push          = i_char_send && i_char_valid && !r_busy;
  assign w_baud_zero     = (r_baud == BAUD_ZERO);
  assign w_fifo_has_data = (r_count != EMPTY_CNT);

  // State register plus FIFO bookkeeping and the serial datapath.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_count   <= EMPTY_CNT;
      r_wr_ptr  <= {FIFO_AW{1'b0}};
      r_rd_ptr  <= {FIFO_AW{1'b0}};
      r_shift   <= 8'h00;
      r_baud    <= BAUD_ZERO;
      r_bit_idx <= 3'd0;
    end else begin
      r_state   <= w_state_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_count_next == FULL_CNT);
      r_count   <= w_count_next;
      r_shift   <= w_shift_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE_PTR;
      end
    end
  end

  // FIFO storage; pointers alone define validity, so the array needs no reset.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_push) begin
      r_mem[r_wr_ptr] <= i_char_to_send;
    end
  end

  // Next-state logic; leaving STOP with data pending chains straight into START.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_has_data) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        if (w_baud_zero) begin
          w_state_next = S_DATA;
        end else begin
          w_state_next = S_START;
        end
      end
      S_DATA: begin
        if (w_baud_zero && (r_bit_idx == 3'd7)) begin
          w_state_next = S_STOP;
        end else begin
          w_state_next = S_DATA;
        end
      end
      S_STOP: begin
        if (w_baud_zero && w_fifo_has_data) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end else if (w_baud_zero) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_STOP;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output/datapath logic; o_tx is computed from the next state so it registers glitch-free.
  always_comb begin
    w_shift_next   = r_shift;
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = 1'b1;
    w_count_next   = r_count;

    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + ONE_CNT;
      2'b01:   w_count_next = r_count - ONE_CNT;
      default: w_count_next = r_count;
    endcase

    if (w_pop) begin
      w_shift_next = r_mem[r_rd_ptr];
      w_baud_next  = BAUD_RELOAD;
    end else if (w_state_next == S_IDLE) begin
      w_baud_next  = BAUD_ZERO;
    end else if (w_baud_zero) begin
      w_baud_next  = BAUD_RELOAD;
      if (r_state == S_DATA) begin
        w_shift_next   = {1'b0, r_shift[7:1]};
        w_bit_idx_next = r_bit_idx + 3'd1;
      end else begin
        w_bit_idx_next = 3'd0;
      end
    end else begin
      w_baud_next  = r_baud - {{(BAUD_W-1){1'b0}}, 1'b1};
    end

    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign o_tx          = r_tx;
  assign o_serial_busy = r_busy;
  assign o_fifo_count  = r_count;

endmodule

// File: tb/tb_saturn_serial_tx.sv
// Directed bench for saturn_serial_tx at 4 clocks per bit and a 4-entry FIFO;
// expected line levels come from a hand-derived 8N1 frame table.
module tb_saturn_serial_tx;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    data;
  logic          valid;
  logic          send;
  logic          busy;
  logic          tx;
  logic [AW:0]   count;

  int n_cmp  = 0;
  int n_fail = 0;

  saturn_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_char_to_send (data),
    .i_char_valid   (valid),
    .i_char_send    (send),
    .o_serial_busy  (busy),
    .o_tx           (tx),
    .o_fifo_count   (count)
  );

  always #5 clk = ~clk;

  // Line level of frame position idx (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0)      return 1'b0;
    else if (idx == 9) return 1'b1;
    else               return b[idx-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_tx(input string tag, input logic exp);
    check(tag, {31'b0, tx}, {31'b0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    check(tag, {29'b0, count}, exp);
  endtask

  task automatic chk_busy(input string tag, input logic exp);
    check(tag, {31'b0, busy}, {31'b0, exp});
  endtask

  // Checks 10*CPB consecutive samples, starting on the first start-bit cycle.
  task automatic check_frame(input logic [7:0] b, input string tag);
    for (int k = 0; k < 10*CPB; k++) begin
      chk_tx(tag, frame_bit(b, k / CPB));
      tick();
    end
  endtask

  initial begin
    // Reset held with a live strobe: nothing may be accepted.
    rst_n = 1'b0; send = 1'b1; valid = 1'b1; data = 8'h5A;
    repeat (3) tick();
    chk_tx("reset_tx", 1'b1);
    chk_busy("reset_busy", 1'b0);
    chk_cnt("reset_count", 0);
    rst_n = 1'b1; send = 1'b0; valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_tx("post_reset_idle_tx", 1'b1);
      chk_cnt("post_reset_count", 0);
    end

    // Strobe without valid is ignored.
    send = 1'b1; valid = 1'b0; data = 8'h33;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_cnt("invalid_count", 0);
      chk_tx("invalid_tx", 1'b1);
    end
    send = 1'b0;
    repeat (2) tick();

    // Single character 0x41.
    send = 1'b1; valid = 1'b1; data = 8'h41;
    tick();
    send = 1'b0; valid = 1'b0;
    chk_cnt("single_accept_count", 1);
    chk_tx("single_accept_tx", 1'b1);
    tick();
    chk_cnt("single_pop_count", 0);
    check_frame(8'h41, "single_frame");
    for (int i = 0; i < 8; i++) begin
      chk_tx("single_idle_after", 1'b1);
      tick();
    end

    // Back-to-back 0x55 then 0xAA with no idle gap.
    send = 1'b1; valid = 1'b1; data = 8'h55;
    tick();
    data = 8'hAA;
    tick();
    send = 1'b0; valid = 1'b0;
    chk_cnt("b2b_count_mid", 1);
    check_frame(8'h55, "b2b_frame0");
    chk_cnt("b2b_count_second_pop", 0);
    check_frame(8'hAA, "b2b_frame1");
    for (int i = 0; i < 8; i++) begin
      chk_tx("b2b_idle_after", 1'b1);
      tick();
    end

    // Backpressure: six strobes, only five accepted; the sixth meets a full FIFO.
    send = 1'b1; valid = 1'b1; data = 8'hC1;
    tick();
    data = 8'hC2;
    tick();
    data = 8'hC3;
    tick();
    data = 8'hC4;
    tick();
    chk_cnt("full_count_e4", 3);
    chk_busy("full_busy_e4", 1'b0);
    data = 8'hC5;
    tick();
    chk_cnt("full_count_e5", 4);
    chk_busy("full_busy_e5", 1'b1);
    data = 8'hC6;
    tick();
    send = 1'b0; valid = 1'b0;
    chk_cnt("full_count_ignored", 4);
    chk_busy("full_busy_held", 1'b1);
    for (int k = 4; k < 10*CPB; k++) begin
      chk_tx("full_frame_c1", frame_bit(8'hC1, k / CPB));
      if (k == 10*CPB - 1) chk_busy("full_busy_last_stop", 1'b1);
      tick();
    end
    chk_busy("full_busy_released", 1'b0);
    chk_cnt("full_count_after_pop", 3);
    check_frame(8'hC2, "full_frame_c2");
    check_frame(8'hC3, "full_frame_c3");
    check_frame(8'hC4, "full_frame_c4");
    check_frame(8'hC5, "full_frame_c5");
    chk_cnt("full_count_drained", 0);
    chk_busy("full_busy_drained", 1'b0);
    for (int i = 0; i < 3*CPB; i++) begin
      chk_tx("full_no_c6_frame", 1'b1);
      tick();
    end

    // Reset during data bit 3 of 0xF0, with 0x0F still queued.
    send = 1'b1; valid = 1'b1; data = 8'hF0;
    tick();
    data = 8'h0F;
    tick();
    send = 1'b0; valid = 1'b0;
    for (int k = 0; k < 4*CPB + 1; k++) begin
      chk_tx("abort_frame_head", frame_bit(8'hF0, k / CPB));
      tick();
    end
    chk_tx("abort_bit3_low", 1'b0);
    chk_cnt("abort_count_before", 1);
    rst_n = 1'b0;
    tick();
    chk_tx("abort_tx_high", 1'b1);
    chk_cnt("abort_count_cleared", 0);
    chk_busy("abort_busy", 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12*CPB; i++) begin
      tick();
      chk_tx("abort_no_resume", 1'b1);
      chk_cnt("abort_stays_empty", 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/saturn_serial_tx.md
Name: saturn_serial_tx

Overview:
- Serial transmit end of the debug character interface driven by saturn_bus_controller (o_char_to_send / o_char_valid / o_char_send, with i_serial_busy returned).
- Buffers characters in a small FIFO and serialises them as 8N1 asynchronous frames on a single TX line.
- Asserts o_serial_busy as backpressure to the controller.
- Instantiated at board top level, beside saturn_bus.

Parameters:
- CLKS_PER_BIT, 217, i_clk cycles per serial bit; must be >= 2. The default gives 115200 baud at 25 MHz.
- FIFO_AW, 4, log2 of FIFO depth; the FIFO holds 2^FIFO_AW entries (default 16).

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset_n  input  1  synchronous reset, active low.
- i_char_to_send  input  8  character byte from bus controller.
- i_char_valid  input  1  i_char_to_send holds a meaningful character.
- i_char_send  input  1  write strobe; one character per asserted cycle.
- o_serial_busy  output  1  FIFO full; the controller must hold its character.
- o_tx  output  1  serial line; idles high.
- o_fifo_count  output  FIFO_AW+1  entries currently buffered (debug).

Behaviour:
- Clock and reset:
  - Single clock i_clk. Reset is synchronous and active low: i_reset_n sampled low on a rising edge resets the block.
  - Reset values: o_tx=1, o_serial_busy=0, o_fifo_count=0, FSM=IDLE, baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame. o_tx is high from the next edge, and FIFO contents are discarded.
- Push rule:
  - A character is accepted on an edge where i_char_send && i_char_valid && !o_serial_busy.
  - A strobe with i_char_valid=0 is ignored.
  - A strobe while busy is ignored; the controller retries, and nothing is dropped silently inside the block.
- o_serial_busy:
  - Registered; equals (count == 2^FIFO_AW).
  - Updates on the edge after the push or pop that changes the count.
- FIFO:
  - Circular buffer with FIFO_AW-bit read and write pointers that wrap modulo 2^FIFO_AW.
  - Count width is FIFO_AW+1.
  - A simultaneous push and pop leaves the count unchanged.
  - A pop when empty never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If count>0, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - START: o_tx=0 for exactly CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held for CLKS_PER_BIT cycles. Bit index runs 0..7; after bit 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles.
  - Leaving STOP: if count>0, pop and go directly to START, giving back-to-back frames with no idle gap; otherwise go to IDLE.
- Baud counter:
  - Counts down to 0; the bit advances on the edge where the counter is 0, then it reloads to CLKS_PER_BIT-1.
- Latency:
  - Push at edge N into an empty FIFO with FSM in IDLE: the pop happens at edge N+1, and o_tx falls after edge N+1.
  - The frame is exactly 10*CLKS_PER_BIT cycles long.
- o_tx must be driven from a register (glitch-free).

Test Plan:
- Reset: hold i_reset_n=0 for 3 cycles with i_char_send=1 -> o_tx=1, o_serial_busy=0, o_fifo_count=0, no frame after release.
- Single char: CLKS_PER_BIT=4, push 0x41 -> o_tx low 1 cycle after accept. Line sequence, 4 cycles each: 0,1,0,0,0,0,0,1,0,1. Then idle high.
- Back-to-back: push 0x55 then 0xAA on consecutive cycles -> 80 cycles of frames with no idle gap. Bits are LSB first: 1,0,1,0.. then 0,1,0,1..
- Full/backpressure: FIFO_AW=2, push 6 chars rapidly -> o_serial_busy=1 when count reaches 4. Strobes while busy are ignored. All accepted chars are transmitted in order, and o_fifo_count returns to 0.
- Invalid strobe: i_char_send=1 with i_char_valid=0, data 0x33 -> no push, o_fifo_count stays 0, o_tx stays 1.
- Reset mid-frame: assert i_reset_n=0 during DATA bit 3 -> o_tx=1 after the next edge. The FIFO is empty and the partial frame is not resumed.
